// File: rtl/posit_data_encode.sv
// Posit encoder: packs sign/scale/fraction fields into an N-bit posit word.
// Two-stage pipeline: S1 builds the regime/exponent/fraction string, S2 rounds, saturates and negates.
module posit_data_encode #(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 0,
  localparam int SW = $clog2((POSIT_WIDTH - 1) << POSIT_ES) + 1,
  localparam int FW = POSIT_WIDTH - 3 - POSIT_ES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rts_i,
  output logic                   rtr_o,
  input  logic                   sign,
  input  logic                   inf,
  input  logic                   zero,
  input  logic [SW-1:0]          scale,
  input  logic [FW-1:0]          fraction,
  input  logic                   sticky_i,
  input  logic                   rtr_i,
  output logic                   rts_o,
  output logic [POSIT_WIDTH-1:0] posit_word_o
);

  localparam int N         = POSIT_WIDTH;
  localparam int EFW       = POSIT_ES + FW;
  localparam int BW        = N + 1 + EFW;
  localparam int MAX_SCALE = (N - 2) << POSIT_ES;

  // Handshake: a stage advances when it is empty or its content leaves on the same edge.
  logic adv1, adv2, load1, load2;
  logic v1_d, v1_q, v2_d, v2_q;

  logic [EFW-1:0]     ef;
  logic signed [31:0] scale_s, k_s, run_s;
  logic [31:0]        shamt;
  logic               fill;
  logic [BW-1:0]      build, shifted;

  logic [N-2:0] kept_d, kept_q;
  logic         guard_d, guard_q, stk_d, stk_q;
  logic         sign_d, sign_q, inf_d, inf_q, zero_d, zero_q;
  logic         smax_d, smax_q, smin_d, smin_q;

  logic         inc;
  logic [N-1:0] sum, mag, enc;
  logic [N-1:0] word_d, word_q;

  if (POSIT_ES == 0) begin : g_no_es
    assign ef = fraction;
  end else begin : g_es
    assign ef = {scale[POSIT_ES-1:0], fraction};
  end

  // Regime run of (k+1) ones or (-k) zeros, then terminator, then e and fraction; left-justify.
  always_comb begin
    scale_s = {{(32-SW){scale[SW-1]}}, scale};
    k_s     = scale_s >>> POSIT_ES;
    fill    = ~k_s[31];
    run_s   = fill ? (k_s + 1) : -k_s;
    shamt   = N - run_s;
    build   = {{N{fill}}, ~fill, ef};
    shifted = build << shamt;
  end

  always_comb begin
    adv2  = ~v2_q | rtr_i;
    adv1  = ~v1_q | adv2;
    load1 = rts_i & adv1;
    load2 = adv2 & v1_q;
    v1_d  = adv1 ? rts_i : v1_q;
    v2_d  = adv2 ? v1_q : v2_q;

    kept_d  = kept_q;
    guard_d = guard_q;
    stk_d   = stk_q;
    sign_d  = sign_q;
    inf_d   = inf_q;
    zero_d  = zero_q;
    smax_d  = smax_q;
    smin_d  = smin_q;
    if (load1) begin
      kept_d  = shifted[BW-1 -: N-1];
      guard_d = shifted[BW-N];
      stk_d   = (|shifted[BW-N-1:0]) | sticky_i;
      sign_d  = sign;
      inf_d   = inf;
      zero_d  = zero;
      smax_d  = scale_s > MAX_SCALE;
      smin_d  = scale_s < -MAX_SCALE;
    end
  end

  // Round to nearest even; a carry into the sign position or a rounded-away value saturates.
  always_comb begin
    inc = guard_q & (stk_q | kept_q[0]);
    sum = {1'b0, kept_q} + {{(N-1){1'b0}}, inc};
    if (smax_q || sum[N-1]) begin
      mag = {1'b0, {(N-1){1'b1}}};
    end else if (smin_q || (sum == '0)) begin
      mag = N'(1);
    end else begin
      mag = sum;
    end
    if (inf_q) begin
      enc = {1'b1, {(N-1){1'b0}}};
    end else if (zero_q) begin
      enc = '0;
    end else begin
      enc = sign_q ? (~mag + N'(1)) : mag;
    end
    word_d = load2 ? enc : word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      kept_q  <= '0;
      guard_q <= 1'b0;
      stk_q   <= 1'b0;
      sign_q  <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      smax_q  <= 1'b0;
      smin_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      kept_q  <= kept_d;
      guard_q <= guard_d;
      stk_q   <= stk_d;
      sign_q  <= sign_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      smax_q  <= smax_d;
      smin_q  <= smin_d;
      word_q  <= word_d;
    end
  end

  assign rtr_o        = adv1;
  assign rts_o        = v2_q;
  assign posit_word_o = word_q;

endmodule

// File: tb/tb_posit_data_encode.sv
// Bench for posit_data_encode: directed vectors, backpressure, mid-stream reset and a full
// extract/encode round trip, checked against a bit-string model of posit encoding.
module tb_posit_data_encode;

  localparam int N  = 16;
  localparam int ES = 0;
  localparam int SW = 5;
  localparam int FW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rts_i = 1'b0;
  logic          rtr_o;
  logic          sign = 1'b0;
  logic          inf = 1'b0;
  logic          zero = 1'b0;
  logic [SW-1:0] scale = '0;
  logic [FW-1:0] fraction = '0;
  logic          sticky_i = 1'b0;
  logic          rtr_i = 1'b1;
  logic          rts_o;
  logic [N-1:0]  posit_word_o;

  posit_data_encode #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o),
    .sign(sign), .inf(inf), .zero(zero), .scale(scale), .fraction(fraction),
    .sticky_i(sticky_i), .rtr_i(rtr_i), .rts_o(rts_o), .posit_word_o(posit_word_o)
  );

  // clock/reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;
  int acc_cnt  = 0;
  bit lat_mode = 1'b0;
  logic [N-1:0] cur_hand = '0;
  bit           cur_has  = 1'b0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] hand_q[$];
  bit           has_q[$];
  int           acc_q[$];

  function automatic void chk(input bit ok, input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Model: lay out regime, exponent and fraction as a bit string, then round the first N-1 bits.
  function automatic logic [N-1:0] model_enc(input bit sg, input bit nf, input bit zr,
                                             input int sc, input int fr, input bit st);
    bit bits[$];
    int k, e, kept;
    bit guard, sticky;
    logic [N-1:0] mag;
    if (nf) return {1'b1, {(N-1){1'b0}}};
    if (zr) return '0;
    if (sc > (N-2) * (1 << ES)) begin
      mag = {1'b0, {(N-1){1'b1}}};
    end else if (sc < -(N-2) * (1 << ES)) begin
      mag = N'(1);
    end else begin
      k = sc >>> ES;
      e = sc - k * (1 << ES);
      if (k >= 0) begin
        repeat (k + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-k) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      for (int i = ES - 1; i >= 0; i--) bits.push_back(bit'((e >> i) & 1));
      for (int i = FW - 1; i >= 0; i--) bits.push_back(bit'((fr >> i) & 1));
      while (bits.size() < N + 1) bits.push_back(1'b0);
      kept = 0;
      for (int i = 0; i < N - 1; i++) kept = kept * 2 + int'(bits[i]);
      guard  = bits[N-1];
      sticky = st;
      for (int i = N; i < bits.size(); i++) sticky = sticky | bits[i];
      if (guard && (sticky || (kept % 2 == 1))) kept++;
      if (kept >= (1 << (N-1))) kept = (1 << (N-1)) - 1;
      if (kept == 0) kept = 1;
      mag = N'(kept);
    end
    return sg ? (~mag + N'(1)) : mag;
  endfunction

  // Reference extraction of a posit word into encoder input fields.
  function automatic void decode(input logic [N-1:0] w, output bit sg, output bit nf,
                                 output bit zr, output int sc, output int fr);
    logic [N-1:0] mag;
    bit r;
    int run, pos, k, e;
    sg = 0; nf = 0; zr = 0; sc = 0; fr = 0;
    if (w == '0) begin zr = 1; return; end
    if (w == {1'b1, {(N-1){1'b0}}}) begin nf = 1; return; end
    sg  = w[N-1];
    mag = sg ? (~w + N'(1)) : w;
    r   = mag[N-2];
    run = 0;
    while (run < N - 1 && mag[N-2-run] == r) run++;
    k   = r ? run - 1 : -run;
    pos = N - 3 - run;
    e = 0;
    for (int i = 0; i < ES; i++) begin
      e = e * 2 + ((pos >= 0) ? int'(mag[pos]) : 0);
      pos--;
    end
    sc = k * (1 << ES) + e;
    for (int i = 0; i < FW; i++) begin
      fr = fr * 2 + ((pos >= 0) ? int'(mag[pos]) : 0);
      pos--;
    end
  endfunction

  // scoreboard: record accepted inputs, check every transferred output word
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); hand_q.delete(); has_q.delete(); acc_q.delete();
    end else begin
      if (rts_o && rtr_i) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", 32'(posit_word_o), 0);
        end else begin
          logic [N-1:0] ex, hd;
          bit hs;
          int ac;
          ex = exp_q.pop_front(); hd = hand_q.pop_front();
          hs = has_q.pop_front(); ac = acc_q.pop_front();
          chk(posit_word_o == ex, "word", 32'(posit_word_o), 32'(ex));
          if (hs) chk(ex == hd, "model_pin", 32'(ex), 32'(hd));
          if (lat_mode) chk(cyc - ac == 2, "latency", 32'(cyc - ac), 2);
        end
      end
      if (rts_i && rtr_o) begin
        exp_q.push_back(model_enc(sign, inf, zero, int'($signed(scale)), int'(fraction), sticky_i));
        hand_q.push_back(cur_hand);
        has_q.push_back(cur_has);
        acc_q.push_back(cyc);
        acc_cnt++;
      end
    end
  end

  // driver tasks
  task automatic send(input bit sg, input bit nf, input bit zr, input int sc, input int fr,
                      input bit st, input logic [N-1:0] hand, input bit has);
    int n;
    sign = sg; inf = nf; zero = zr; scale = SW'(sc); fraction = FW'(fr); sticky_i = st;
    cur_hand = hand; cur_has = has; rts_i = 1'b1;
    @(negedge clk);
    n = 0;
    while (!rtr_o && n < 100) begin @(negedge clk); n++; end
    if (!rtr_o) chk(1'b0, "send_timeout", 0, 1);
    @(posedge clk); #1;
    rts_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  bit bp_done = 1'b0;
  int acc0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk(rts_o == 1'b0, "reset_rts_o", 32'(rts_o), 0);
    chk(rtr_o == 1'b1, "reset_rtr_o", 32'(rtr_o), 1);
    chk(posit_word_o == '0, "reset_word", 32'(posit_word_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk(model_enc(0, 0, 0, 0, 0, 0) == 16'h4000, "pin_s0", 32'(model_enc(0, 0, 0, 0, 0, 0)), 32'h4000);
    chk(model_enc(0, 0, 0, -1, 0, 0) == 16'h2000, "pin_sm1", 32'(model_enc(0, 0, 0, -1, 0, 0)), 32'h2000);
    chk(model_enc(0, 0, 0, 1, 3, 0) == 16'h6002, "pin_rnd", 32'(model_enc(0, 0, 0, 1, 3, 0)), 32'h6002);

    // directed vectors, rtr_i held high
    lat_mode = 1'b1;
    send(0, 0, 0,   0,      0, 0, 16'h4000, 1);
    send(0, 0, 0,   1,      0, 0, 16'h6000, 1);
    send(0, 0, 0,  -1,      0, 0, 16'h2000, 1);
    send(1, 0, 0,   0,      0, 0, 16'hC000, 1);
    send(0, 0, 1,   5, 13'h1F, 0, 16'h0000, 1);
    send(1, 0, 1,  -3,      7, 1, 16'h0000, 1);
    send(0, 1, 1,   3,      0, 0, 16'h8000, 1);
    send(1, 1, 0,  -7,     99, 1, 16'h8000, 1);
    send(0, 0, 0,  14,      0, 0, 16'h7FFF, 1);
    send(0, 0, 0,  15,      0, 0, 16'h7FFF, 1);
    send(0, 0, 0, -16,      0, 0, 16'h0001, 1);
    send(0, 0, 0, -15,      0, 0, 16'h0001, 1);
    send(0, 0, 0, -14,      0, 0, 16'h0001, 1);
    send(1, 0, 0,  15,      0, 0, 16'h8001, 1);
    send(0, 0, 0,   1,      1, 0, 16'h6000, 1);
    send(0, 0, 0,   1,      3, 0, 16'h6002, 1);
    send(0, 0, 0,   1,      1, 1, 16'h6001, 1);
    send(1, 0, 0,   1,      3, 0, 16'h9FFE, 1);
    send(0, 0, 0,  13, 13'h1000, 0, 16'h7FFE, 1);
    send(0, 0, 0,  13, 13'h1000, 1, 16'h7FFF, 1);
    send(0, 0, 0,   0, 13'h1FFF, 1, 16'h5FFF, 1);
    drain();

    // backpressure: two fill the pipe, the third waits
    lat_mode = 1'b0;
    rtr_i = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        send(0, 0, 0,  2, 0, 0, 16'h7000, 1);
        send(0, 0, 0, -2, 0, 0, 16'h1000, 1);
        send(1, 0, 0,  0, 0, 0, 16'hC000, 1);
        bp_done = 1'b1;
      end
    join_none
    repeat (6) @(negedge clk);
    #1;
    chk(rtr_o == 1'b0, "bp_rtr_o", 32'(rtr_o), 0);
    chk(acc_cnt - acc0 == 2, "bp_accepted", 32'(acc_cnt - acc0), 2);
    for (int i = 0; i < 3; i++) begin
      chk(rts_o == 1'b1, "bp_hold_rts", 32'(rts_o), 1);
      chk(posit_word_o == 16'h7000, "bp_hold_word", 32'(posit_word_o), 32'h7000);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rtr_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk(rts_o == 1'b1, "bp_stream", 32'(rts_o), 1);
    end
    chk(acc_cnt - acc0 == 3, "bp_third", 32'(acc_cnt - acc0), 3);
    for (int n = 0; n < 50 && !bp_done; n++) @(posedge clk);
    chk(bp_done == 1'b1, "bp_done", 32'(bp_done), 1);
    drain();

    // reset with both stages full
    rtr_i = 1'b0;
    send(0, 0, 0,  3, 0, 0, 16'h7800, 1);
    send(0, 0, 0, -3, 0, 0, 16'h0800, 1);
    @(negedge clk); #1;
    chk(rtr_o == 1'b0, "rst_pre_rtr", 32'(rtr_o), 0);
    chk(rts_o == 1'b1, "rst_pre_rts", 32'(rts_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk(rts_o == 1'b0, "rst_async_rts", 32'(rts_o), 0);
    chk(rtr_o == 1'b1, "rst_async_rtr", 32'(rtr_o), 1);
    chk(posit_word_o == '0, "rst_async_word", 32'(posit_word_o), 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rtr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk(rts_o == 1'b0, "no_stale", 32'(rts_o), 0);
    end
    @(posedge clk); #1;
    lat_mode = 1'b1;
    send(0, 0, 0, 4, 0, 0, 16'h7C00, 1);
    drain();

    // round trip over every word
    for (int w = 0; w < (1 << N); w++) begin
      bit sg, nf, zr;
      int sc, fr;
      decode(N'(w), sg, nf, zr, sc, fr);
      send(sg, nf, zr, sc, fr, 0, N'(w), 1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
